// File: rtl/ilkn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ilkn_pkg
// Description : Control-word constants, header codes and word-position kinds
//               shared by the single-lane Interlaken meta-frame transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package ilkn_pkg;

  localparam logic [63:0] SYNC_WORD       = 64'h78f678f678f678f6;
  localparam logic [63:0] SCR_WORD_PREFIX = 64'h2800000000000000;
  localparam logic [63:0] SKIP_WORD       = 64'h1e1e1e1e1e1e1e1e;
  localparam logic [63:0] DIAG_PREFIX     = 64'h6400000000000000;
  localparam logic [63:0] IDLE_WORD       = 64'haaaaaaaaaaaaaaaa;

  localparam logic [1:0]  HDR_DATA = 2'b01;
  localparam logic [1:0]  HDR_CTRL = 2'b10;

  // Role of a word position inside the meta-frame
  typedef enum logic [2:0] {
    KIND_SYNC    = 3'd0,
    KIND_SCR     = 3'd1,
    KIND_SKIP    = 3'd2,
    KIND_PAYLOAD = 3'd3,
    KIND_DIAG    = 3'd4
  } word_kind_e;

endpackage : ilkn_pkg
`default_nettype wire

// File: rtl/tx_slot_cadence.sv
`default_nettype none
// ============================================================================
// Module      : tx_slot_cadence
// Description : Fractional accumulator producing GB_NUM word slots for every
//               GB_DEN clock cycles, spread as evenly as the ratio allows.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_slot_cadence #(
  parameter int GB_NUM = 22,
  parameter int GB_DEN = 67
) (
  input  logic clk,
  input  logic rst,
  output logic slot
);

  localparam int ACC_W = $clog2(GB_DEN + 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   nxt;
  logic [ACC_W:0]   wrapped;

  // One extra bit so acc+GB_NUM never overflows before the compare
  assign nxt     = {1'b0, acc} + (ACC_W + 1)'(GB_NUM);
  assign slot    = (nxt >= (ACC_W + 1)'(GB_DEN));
  assign wrapped = nxt - (ACC_W + 1)'(GB_DEN);

  // Accumulator keeps the fractional remainder between slots
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (slot) begin
      acc <= wrapped[ACC_W-1:0];
    end else begin
      acc <= nxt[ACC_W-1:0];
    end
  end

endmodule : tx_slot_cadence
`default_nettype wire

// File: rtl/tx_metaframer.sv
`default_nettype none
// ============================================================================
// Module      : tx_metaframer
// Description : Builds Interlaken meta-frames on one lane (sync, scrambler
//               state, skip, payload, diagnostic) on a fractional slot
//               cadence, fed from a valid/ready source via one holding reg.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_metaframer
  import ilkn_pkg::*;
#(
  parameter int          META_FRAME_LEN = 16,
  parameter int          GB_NUM         = 22,
  parameter int          GB_DEN         = 67,
  parameter logic [57:0] SCR_STATE_INIT = 58'h0
) (
  input  logic        USER_CLK,
  input  logic        SYSTEM_RESET,
  input  logic [63:0] DATA_IN,
  input  logic        DATA_IN_VALID,
  output logic        DATA_IN_READY,
  input  logic [1:0]  LANE_STATUS,
  output logic [63:0] DATA_OUT,
  output logic [1:0]  HEADER_OUT,
  output logic        DATA_OUT_VALID,
  output logic        FRAME_START,
  output logic        UNDERRUN
);

  localparam int CTR_W = $clog2(META_FRAME_LEN);
  localparam logic [CTR_W-1:0] LAST_POS = CTR_W'(META_FRAME_LEN - 1);

  logic             slot;
  logic [CTR_W-1:0] word_ctr;
  word_kind_e       kind;
  logic             consume;
  logic             accept;
  logic             hold_full;
  logic [63:0]      hold_data;

  logic [63:0]      data_nxt;
  logic [1:0]       hdr_nxt;
  logic             valid_nxt;
  logic             fs_nxt;
  logic             ur_nxt;

  tx_slot_cadence #(
    .GB_NUM (GB_NUM),
    .GB_DEN (GB_DEN)
  ) u_cadence (
    .clk  (USER_CLK),
    .rst  (SYSTEM_RESET),
    .slot (slot)
  );

  // Classify the current word position; the last position wins over payload
  always_comb begin
    kind = KIND_PAYLOAD;
    if (word_ctr == CTR_W'(0)) begin
      kind = KIND_SYNC;
    end else if (word_ctr == CTR_W'(1)) begin
      kind = KIND_SCR;
    end else if (word_ctr == CTR_W'(2)) begin
      kind = KIND_SKIP;
    end else if (word_ctr == LAST_POS) begin
      kind = KIND_DIAG;
    end
  end

  // Ready also when the held word leaves this cycle, so a full stream never stalls
  assign consume       = slot && (kind == KIND_PAYLOAD) && hold_full;
  assign DATA_IN_READY = !hold_full || consume;
  assign accept        = DATA_IN_VALID && DATA_IN_READY;

  // Word position advances only on slot cycles and wraps at the frame end
  always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) begin
      word_ctr <= '0;
    end else if (slot) begin
      word_ctr <= (word_ctr == LAST_POS) ? '0 : word_ctr + CTR_W'(1);
    end
  end

  // Single holding register; a same-cycle consume and accept reloads it
  always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_data <= DATA_IN;
    end else if (consume) begin
      hold_full <= 1'b0;
    end
  end

  // Select the lane word for this slot; non-slot cycles produce an all-zero bubble
  always_comb begin
    data_nxt  = '0;
    hdr_nxt   = '0;
    valid_nxt = 1'b0;
    fs_nxt    = 1'b0;
    ur_nxt    = 1'b0;
    if (slot) begin
      valid_nxt = 1'b1;
      hdr_nxt   = HDR_CTRL;
      unique case (kind)
        KIND_SYNC: begin
          data_nxt = SYNC_WORD;
          fs_nxt   = 1'b1;
        end
        KIND_SCR:  data_nxt = SCR_WORD_PREFIX | {6'd0, SCR_STATE_INIT};
        KIND_SKIP: data_nxt = SKIP_WORD;
        // CRC32 field is left at zero in this generation
        KIND_DIAG: data_nxt = DIAG_PREFIX | {30'd0, LANE_STATUS, 32'd0};
        default: begin
          if (hold_full) begin
            hdr_nxt  = HDR_DATA;
            data_nxt = hold_data;
          end else begin
            data_nxt = IDLE_WORD;
            ur_nxt   = 1'b1;
          end
        end
      endcase
    end
  end

  // Output stage: one cycle of latency from slot decision to lane
  always_ff @(posedge USER_CLK or posedge SYSTEM_RESET) begin
    if (SYSTEM_RESET) begin
      DATA_OUT       <= '0;
      HEADER_OUT     <= '0;
      DATA_OUT_VALID <= 1'b0;
      FRAME_START    <= 1'b0;
      UNDERRUN       <= 1'b0;
    end else begin
      DATA_OUT       <= data_nxt;
      HEADER_OUT     <= hdr_nxt;
      DATA_OUT_VALID <= valid_nxt;
      FRAME_START    <= fs_nxt;
      UNDERRUN       <= ur_nxt;
    end
  end

endmodule : tx_metaframer
`default_nettype wire
